udp_reg_bridge: RTL and testbench

Register-access bridge on the UDP payload path of the Ethernet stack. It consumes the received port-1234 payload byte stream (`rx_fifo_udp_payload_*`), decodes each packet as a single read or write command, and executes it on a simple request/acknowledge register bus. It then emits a fixed 9-byte response payload on the transmit payload stream (`tx_fifo_udp_payload_*`), which the UDP stack returns to the sender.

---
 rtl/udp_reg_bridge_pkg.sv | 24 ++
 rtl/udp_reg_resp_tx.sv | 51 +++++
 rtl/udp_reg_bridge.sv | 177 +++++++++++++++++
 tb/tb_udp_reg_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_reg_bridge_pkg.sv
// Shared constants and types for the UDP register-access bridge.
package udp_reg_bridge_pkg;

    localparam int unsigned RESP_LEN = 9;
    localparam int unsigned IDX_W    = 4;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;

    localparam logic [7:0] ST_WR_OK  = 8'h81;
    localparam logic [7:0] ST_RD_OK  = 8'h82;
    localparam logic [7:0] ST_WR_TMO = 8'hE1;
    localparam logic [7:0] ST_RD_TMO = 8'hE2;
    localparam logic [7:0] ST_BAD_OP = 8'hEE;

    typedef enum logic [1:0] {RECV, EXEC, SEND} state_t;

    typedef struct packed {
        logic [7:0]  status;
        logic [31:0] addr;
        logic [31:0] data;
    } resp_t;

endpackage

// File: rtl/udp_reg_resp_tx.sv
// Serializes a 9-byte response onto an AXI-stream master; done_c pulses on
// the accepted last byte.
module udp_reg_resp_tx
    import udp_reg_bridge_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load_c,
    input  resp_t      resp,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       done_c
);

    localparam int unsigned BIT_W = RESP_LEN * 8;

    logic [BIT_W-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic             xfer_c;

    assign xfer_c       = m_axis_tvalid & m_axis_tready;
    assign done_c       = xfer_c & m_axis_tlast;
    assign m_axis_tdata = shreg[BIT_W-1 -: 8];
    assign m_axis_tuser = 1'b0;

    // Current byte sits in the top of the shift register, so data holds while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg         <= '0;
            idx           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (load_c) begin
            shreg         <= resp;
            idx           <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
        end else if (xfer_c) begin
            shreg        <= {shreg[BIT_W-9:0], 8'h00};
            idx          <= idx + IDX_W'(1);
            m_axis_tlast <= (idx == IDX_W'(RESP_LEN - 2));
            if (m_axis_tlast) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/udp_reg_bridge.sv
// Decodes UDP payload packets into single register reads/writes and returns a
// 9-byte status response. Optional bus timeout: UDP_REG_BRIDGE_TIMEOUT_EN.
module udp_reg_bridge
    import udp_reg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [7:0]       opcode, opcode_next;
    logic [31:0]      addr_next, wdata_next;
    logic             req_next, we_next;
    logic             accept_c, load_c, done_c, tmo_c;
    resp_t            resp_c;

    assign accept_c = s_axis_tvalid & s_axis_tready;

`ifdef UDP_REG_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles of bus_req high; zero on the first EXEC cycle.
    always_ff @(posedge clock) begin
        if (reset || state != EXEC) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_c = (state == EXEC) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_c = 1'b0;
`endif

    // Next-state, capture and response selection.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        opcode_next = opcode;
        addr_next   = bus_addr;
        wdata_next  = bus_wdata;
        req_next    = bus_req;
        we_next     = bus_we;
        load_c      = 1'b0;
        resp_c      = '0;

        unique case (state)
            RECV: begin
                if (accept_c) begin
                    case (idx)
                        4'd0: begin
                            opcode_next = s_axis_tdata;
                            addr_next   = '0;
                            wdata_next  = '0;
                        end
                        4'd1: addr_next[31:24]  = s_axis_tdata;
                        4'd2: addr_next[23:16]  = s_axis_tdata;
                        4'd3: addr_next[15:8]   = s_axis_tdata;
                        4'd4: addr_next[7:0]    = s_axis_tdata;
                        4'd5: wdata_next[31:24] = s_axis_tdata;
                        4'd6: wdata_next[23:16] = s_axis_tdata;
                        4'd7: wdata_next[15:8]  = s_axis_tdata;
                        4'd8: wdata_next[7:0]   = s_axis_tdata;
                        default: ;
                    endcase
                    idx_next = (idx == 4'd9) ? idx : idx + 4'd1;

                    // idx is the index of the last byte, so length = idx + 1.
                    if (s_axis_tlast) begin
                        idx_next = '0;
                        if (!s_axis_tuser) begin
                            if (opcode_next == OP_WRITE) begin
                                if (idx >= 4'd8) begin
                                    state_next = EXEC;
                                    req_next   = 1'b1;
                                    we_next    = 1'b1;
                                end
                            end else if (opcode_next == OP_READ) begin
                                if (idx >= 4'd4) begin
                                    state_next = EXEC;
                                    req_next   = 1'b1;
                                    we_next    = 1'b0;
                                end
                            end else begin
                                state_next    = SEND;
                                load_c        = 1'b1;
                                resp_c.status = ST_BAD_OP;
                                resp_c.addr   = addr_next;
                                resp_c.data   = wdata_next;
                            end
                        end
                    end
                end
            end
            EXEC: begin
                if (bus_ack) begin
                    state_next    = SEND;
                    req_next      = 1'b0;
                    load_c        = 1'b1;
                    resp_c.status = bus_we ? ST_WR_OK : ST_RD_OK;
                    resp_c.addr   = bus_addr;
                    resp_c.data   = bus_we ? bus_wdata : bus_rdata;
                end else if (tmo_c) begin
                    state_next    = SEND;
                    req_next      = 1'b0;
                    load_c        = 1'b1;
                    resp_c.status = bus_we ? ST_WR_TMO : ST_RD_TMO;
                    resp_c.addr   = bus_addr;
                    resp_c.data   = '0;
                end
            end
            SEND: begin
                if (done_c) begin
                    state_next = RECV;
                end
            end
            default: state_next = RECV;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RECV;
            idx           <= '0;
            opcode        <= '0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= state_next;
            idx           <= idx_next;
            opcode        <= opcode_next;
            bus_addr      <= addr_next;
            bus_wdata     <= wdata_next;
            bus_req       <= req_next;
            bus_we        <= we_next;
            s_axis_tready <= (state_next == RECV);
        end
    end

    udp_reg_resp_tx u_resp_tx (
        .clock         (clock),
        .reset         (reset),
        .load_c        (load_c),
        .resp          (resp_c),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .done_c        (done_c)
    );

endmodule

// File: tb/tb_udp_reg_bridge.sv
// Randomized bench for udp_reg_bridge against a packet-level command/response model.
module tb_udp_reg_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic        has_bus;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        has_resp;
        logic [7:0]  status;
        logic [31:0] data;
    } exp_t;

    udp_reg_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference decode of one packet as the sender sees it.
    function automatic exp_t model(input byte_q_t pkt, input logic bad);
        exp_t       e;
        logic [7:0] b [9];
        for (int i = 0; i < 9; i++) b[i] = (i < pkt.size()) ? pkt[i] : 8'h00;
        e = '{default: '0};
        e.addr  = {b[1], b[2], b[3], b[4]};
        e.wdata = {b[5], b[6], b[7], b[8]};
        if (bad) return e;
        if (b[0] == 8'h01) begin
            if (pkt.size() >= 9) begin
                e.has_bus = 1; e.we = 1; e.has_resp = 1; e.status = 8'h81; e.data = e.wdata;
            end
        end else if (b[0] == 8'h02) begin
            if (pkt.size() >= 5) begin
                e.has_bus = 1; e.we = 0; e.has_resp = 1; e.status = 8'h82;
            end
        end else begin
            e.has_resp = 1; e.status = 8'hEE; e.data = e.wdata;
        end
        return e;
    endfunction

    // Drives a packet with idle gaps carrying junk, including stray bus_ack pulses.
    task automatic send_pkt(input byte_q_t pkt, input logic bad);
        for (int i = 0; i < pkt.size(); i++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = 8'($urandom);
                s_axis_tlast  = 1'($urandom);
                s_axis_tuser  = 1'($urandom);
                bus_ack       = 1'($urandom);
                bus_rdata     = $urandom;
                step();
            end
            bus_ack       = 1'b0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pkt[i];
            s_axis_tlast  = (i == pkt.size() - 1);
            s_axis_tuser  = s_axis_tlast ? bad : 1'($urandom);
            chk("rx_ready", s_axis_tready, 1);
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random.
    task automatic collect(input logic [71:0] exp, input int mode);
        int         k = 0;
        int         cyc = 0;
        logic       stalled = 0;
        logic [8:0] held = '0;
        while (k < 9 && cyc < 200) begin
            if (stalled) chk("tx_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
            m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom);
            if (m_axis_tvalid && m_axis_tready) begin
                chk($sformatf("tx_byte%0d", k), {m_axis_tuser, m_axis_tlast, m_axis_tdata},
                    {1'b0, k == 8, exp[71 - 8*k -: 8]});
                k++;
                stalled = 0;
            end else begin
                stalled = m_axis_tvalid;
                held    = {m_axis_tlast, m_axis_tdata};
            end
            step();
            cyc++;
        end
        if (k < 9) chk("tx_bytes_seen", 72'(k), 72'd9);
        if (mode == 0) chk("tx_rate", 72'(cyc), 72'd9);
        m_axis_tready = 1'b0;
        chk("tx_done", {m_axis_tvalid, s_axis_tready}, 2'b01);
    endtask

    // ack_dly < 0 means never acknowledge (timeout build only).
    task automatic run_pkt(input byte_q_t pkt, input logic bad, input int ack_dly,
                           input logic [31:0] rdata, input int mode);
        exp_t e = model(pkt, bad);
        send_pkt(pkt, bad);
        chk("rx_ready_after_last", s_axis_tready, !(e.has_bus || e.has_resp));
        chk("req_at_t1", bus_req, e.has_bus);
        chk("tvalid_at_t1", m_axis_tvalid, e.has_resp && !e.has_bus);
        if (e.has_bus) begin
            chk("bus_we", bus_we, e.we);
            chk("bus_addr", bus_addr, e.addr);
            if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
            if (ack_dly < 0) begin
                repeat (7) begin
                    step();
                    chk("req_wait_tmo", {bus_req, bus_addr}, {1'b1, e.addr});
                end
                step();
                e.status = e.we ? 8'hE1 : 8'hE2;
                e.data   = '0;
            end else begin
                repeat (ack_dly) begin
                    step();
                    chk("req_hold", {bus_req, bus_we, bus_addr}, {1'b1, e.we, e.addr});
                end
                bus_ack   = 1'b1;
                bus_rdata = rdata;
                step();
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
                if (!e.we) e.data = rdata;
            end
            chk("req_drop", bus_req, 0);
            chk("tvalid_after_ack", m_axis_tvalid, 1);
        end
        if (e.has_resp) begin
            collect({e.status, e.addr, e.data}, mode);
        end else begin
            repeat (3) begin
                step();
                chk("drop_quiet", {bus_req, m_axis_tvalid, s_axis_tready}, 3'b001);
            end
        end
    endtask

    initial begin
        byte_q_t pkt;
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("reset_ctl", {s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
                              m_axis_tuser, bus_req, bus_we}, '0);
            chk("reset_bus", {bus_addr, bus_wdata}, '0);
        end
        reset = 1'b0;
        chk("tready_first_cycle", s_axis_tready, 0);
        step();
        chk("tready_up", s_axis_tready, 1);

        pkt = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_pkt(pkt, 0, 2, 32'h0, 0);
        pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h20};
        run_pkt(pkt, 0, 3, 32'h12345678, 0);
        pkt = '{8'h02, 8'h00, 8'h00};
        run_pkt(pkt, 0, 0, 32'h0, 0);
        pkt = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(pkt, 1, 0, 32'h0, 0);
        pkt = '{8'h02, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        run_pkt(pkt, 0, 0, 32'hCAFEF00D, 2);
        pkt = '{8'h55, 8'hAB};
        run_pkt(pkt, 0, 0, 32'h0, 0);
        pkt = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'hF1, 8'hF2, 8'hF3};
        run_pkt(pkt, 0, 1, 32'h0, 1);
`ifdef UDP_REG_BRIDGE_TIMEOUT_EN
        pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h40};
        run_pkt(pkt, 0, -1, 32'h0, 0);
`endif

        // Reset mid-packet: the partial write must leave no trace.
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = (i == 0) ? 8'h01 : 8'h77;
            s_axis_tlast  = 1'b0;
            step();
        end
        s_axis_tvalid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("mid_pkt_reset", {bus_req, m_axis_tvalid, s_axis_tready, bus_addr}, {3'b001, 32'h0});
        pkt = '{8'h02, 8'h00, 8'h00};
        run_pkt(pkt, 0, 0, 32'h0, 0);

        // Reset mid-access: no response may follow.
        pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h50};
        send_pkt(pkt, 0);
        chk("mid_acc_req", bus_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_acc_reset", {bus_req, m_axis_tvalid}, 2'b00);
        step();
        chk("mid_acc_ready", {bus_req, m_axis_tvalid, s_axis_tready}, 3'b001);

        for (int n = 0; n < 40; n++) begin
            int         r   = $urandom_range(0, 99);
            int         len;
            logic [7:0] op;
            logic       bad = ($urandom_range(0, 9) == 0);
            if (r < 45) begin
                op = 8'h01; len = $urandom_range(7, 12);
            end else if (r < 85) begin
                op = 8'h02; len = $urandom_range(3, 8);
            end else begin
                do op = 8'($urandom); while (op == 8'h01 || op == 8'h02);
                len = $urandom_range(1, 10);
            end
            pkt = '{};
            pkt.push_back(op);
            for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
            run_pkt(pkt, bad, $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
